// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the single-transfer master state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_e;

endpackage

// File: rtl/ahb_master_single.sv
// AHB-Lite initiator: one valid/ready command becomes one SINGLE NONSEQ word transfer,
// completion reported on a one-cycle rsp_valid pulse; a wait-state watchdog forces progress.
module ahb_master_single
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [31:0] hrdata,
  input  logic        hresp
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [31:0]     haddr_q;
  logic [1:0]      htrans_q;
  logic            hwrite_q;
  logic [31:0]     hwdata_q;
  logic [31:0]     wdata_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic [TO_W-1:0] wd_q;
  logic            wd_expired;

  // Fires on the TIMEOUT_CYCLES-th consecutive hready-low cycle of a phase.
  assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == TO_LAST);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_IDLE;
      haddr_q     <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          wd_q     <= '0;
          htrans_q <= HTRANS_IDLE;
          if (cmd_valid) begin
            haddr_q  <= cmd_addr;
            hwrite_q <= cmd_write;
            wdata_q  <= cmd_wdata;
            htrans_q <= HTRANS_NONSEQ;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (hready) begin
            htrans_q <= HTRANS_IDLE;
            if (hwrite_q) begin
              hwdata_q <= wdata_q;
            end
            wd_q    <= '0;
            state_q <= ST_DATA;
          end else if (wd_expired) begin
            // Abort breaks the AHB hold rule on purpose: recovery from a hung slave.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            htrans_q    <= HTRANS_IDLE;
            wd_q        <= '0;
            state_q     <= ST_IDLE;
          end else begin
            wd_q <= wd_q + TO_W'(1);
          end
        end
        ST_DATA: begin
          if (hready) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= hresp;
            rsp_rdata_q <= hwrite_q ? 32'h0 : hrdata;
            state_q     <= ST_IDLE;
          end else if (wd_expired) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            htrans_q    <= HTRANS_IDLE;
            wd_q        <= '0;
            state_q     <= ST_IDLE;
          end else begin
            wd_q <= wd_q + TO_W'(1);
          end
        end
        default: begin
          htrans_q <= HTRANS_IDLE;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hsize     = HSIZE_WORD;
  assign hburst    = HBURST_SINGLE;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
